cpu_gen2: RTL and testbench

- Second-generation 8-bit sequential CPU, the drop-in successor of the current single-accumulator core.
- Generalises addressing width, register count and subroutine depth.
- Adds a general register file, a full ALU op set, carry/zero conditional branches and JSR/RTS with a bounded hardware return stack with fault detection.
- Sits between the synchronous block RAM (2-cycle read latency, write-while-read allowed) and the UART tx/rx pair.

---
 rtl/cpu_gen2_pkg.sv | 60 ++++++
 rtl/cpu_gen2_alu.sv | 41 ++++
 rtl/cpu_gen2.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_cpu_gen2.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_gen2_pkg.sv
// Shared encodings for the cpu_gen2 core: FSM states, opcodes, ALU ops, flag bits.
package cpu_gen2_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned STATE_W = 4;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_WAIT    = 4'd2;
  localparam logic [3:0] S_OPLOAD  = 4'd3;
  localparam logic [3:0] S_DECODE  = 4'd4;
  localparam logic [3:0] S_WAIT2   = 4'd5;
  localparam logic [3:0] S_OPLOAD2 = 4'd6;
  localparam logic [3:0] S_EXEC    = 4'd7;
  localparam logic [3:0] S_WAIT3   = 4'd8;
  localparam logic [3:0] S_MEMLOAD = 4'd9;
  localparam logic [3:0] S_TXWAIT  = 4'd10;
  localparam logic [3:0] S_RXWAIT  = 4'd11;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_ADC = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_SBC = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_XOR = 3'd6;
  localparam logic [2:0] ALU_CMP = 3'd7;

  localparam logic [7:0] OP_HLT = 8'h00;
  localparam logic [7:0] OP_OUT = 8'h01;
  localparam logic [7:0] OP_IN  = 8'h02;
  localparam logic [7:0] OP_CLF = 8'h03;
  localparam logic [7:0] OP_RTS = 8'h04;

  localparam logic [7:0] MOV_MASK = 8'hF0;
  localparam logic [7:0] MOV_BASE = 8'h10;
  localparam logic [7:0] ALU_MASK = 8'hC0;
  localparam logic [7:0] ALU_BASE = 8'h40;
  localparam logic [7:0] REG_MASK = 8'hFC;
  localparam logic [7:0] LDI_BASE = 8'h80;
  localparam logic [7:0] LD_BASE  = 8'h84;
  localparam logic [7:0] ST_BASE  = 8'h88;
  localparam logic [7:0] JSR_MASK = 8'hF8;
  localparam logic [7:0] JSR_BASE = 8'hA0;

  localparam logic [7:0] OP_BRA  = 8'h90;
  localparam logic [7:0] OP_BRZ  = 8'h91;
  localparam logic [7:0] OP_BRNZ = 8'h92;
  localparam logic [7:0] OP_BRC  = 8'h93;
  localparam logic [7:0] OP_BRNC = 8'h94;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;

  function automatic logic op_match(input logic [7:0] op, input logic [7:0] mask,
                                    input logic [7:0] base);
    return (op & mask) == base;
  endfunction

endpackage

// File: rtl/cpu_gen2_alu.sv
// Combinational 8-bit ALU; carry_out is carry for adds and borrow for subtracts.
module cpu_gen2_alu
  import cpu_gen2_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  input  logic [2:0] op,
  output logic [7:0] result,
  output logic       carry_out,
  output logic       zero
);

  logic       cin_eff;
  logic [8:0] sum;
  logic [8:0] diff;

  always_comb begin
    cin_eff   = (op == ALU_ADC || op == ALU_SBC) ? cin : 1'b0;
    sum       = {1'b0, a} + {1'b0, b} + {8'd0, cin_eff};
    // 9-bit difference goes negative exactly when a < b + cin
    diff      = {1'b0, a} - {1'b0, b} - {8'd0, cin_eff};
    result    = '0;
    carry_out = 1'b0;
    case (op)
      ALU_ADD, ALU_ADC: begin
        result    = sum[7:0];
        carry_out = sum[8];
      end
      ALU_SUB, ALU_SBC, ALU_CMP: begin
        result    = diff[7:0];
        carry_out = diff[8];
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = a ^ b;
    endcase
    zero = (result == 8'd0);
  end

endmodule

// File: rtl/cpu_gen2.sv
// Second-generation 8-bit sequential CPU: register file, ALU, conditional branches,
// JSR/RTS over a bounded return stack with overflow/underflow fault.
module cpu_gen2
  import cpu_gen2_pkg::*;
#(
  parameter int unsigned addr_width  = 9,
  parameter int unsigned nregs       = 4,
  parameter int unsigned stack_depth = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [addr_width-1:0] startaddr,
  input  logic [7:0]            dread,
  output logic [addr_width-1:0] c_raddr,
  output logic [addr_width-1:0] c_waddr,
  output logic [7:0]            dwrite,
  output logic                  write_en,
  output logic [7:0]            tx_byte,
  output logic                  transmit,
  input  logic                  is_transmitting,
  input  logic                  received,
  input  logic [7:0]            rx_byte,
  output logic                  halted,
  output logic                  fault,
  output logic                  led
);

  localparam int unsigned AW    = addr_width;
  localparam int unsigned SPW   = $clog2(stack_depth + 1);
  localparam int unsigned SLOTS = 1 << SPW;

  logic [STATE_W-1:0] state, state_d;
  logic [AW-1:0]      pc, pc_d;
  logic [7:0]         opcode, opcode_d, operand, operand_d;
  logic [1:0]         flags, flags_d;
  logic [SPW-1:0]     sp, sp_d, sp_dec;
  logic [7:0]         regs [4];
  logic [AW-1:0]      stack [SLOTS];

  logic               reg_we;
  logic [1:0]         reg_wsel;
  logic [7:0]         reg_wdata;
  logic               push;

  logic [AW-1:0]      c_raddr_d, c_waddr_d;
  logic [7:0]         dwrite_d, tx_byte_d;
  logic               write_en_d, transmit_d, halted_d, fault_d, led_d;

  logic [AW-1:0]      pc_inc, br_target, jsr_target;
  logic               br_taken;
  logic [1:0]         rs, rd;
  logic [7:0]         alu_result;
  logic               alu_carry, alu_zero;

  function automatic logic reg_ok(input logic [1:0] idx);
    return (nregs == 4) || !idx[1];
  endfunction

  assign rs         = opcode[1:0];
  assign rd         = opcode[3:2];
  assign sp_dec     = SPW'(sp - 1'b1);
  assign pc_inc     = AW'(pc + 1'b1);
  // operand is a signed displacement from the address just past it
  assign br_target  = AW'(pc + AW'($signed(operand)));
  assign jsr_target = AW'({opcode[2:0], operand});

  cpu_gen2_alu u_alu (
    .a         (regs[0]),
    .b         (regs[rs]),
    .cin       (flags[FLAG_C]),
    .op        (opcode[5:3]),
    .result    (alu_result),
    .carry_out (alu_carry),
    .zero      (alu_zero)
  );

  always_comb begin
    case (opcode)
      OP_BRA:  br_taken = 1'b1;
      OP_BRZ:  br_taken = flags[FLAG_Z];
      OP_BRNZ: br_taken = !flags[FLAG_Z];
      OP_BRC:  br_taken = flags[FLAG_C];
      OP_BRNC: br_taken = !flags[FLAG_C];
      default: br_taken = 1'b0;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    opcode_d   = opcode;
    operand_d  = operand;
    flags_d    = flags;
    sp_d       = sp;
    fault_d    = fault;
    c_raddr_d  = c_raddr;
    c_waddr_d  = c_waddr;
    dwrite_d   = dwrite;
    tx_byte_d  = tx_byte;
    write_en_d = 1'b0;
    transmit_d = 1'b0;
    halted_d   = 1'b0;
    led_d      = 1'b0;
    reg_we     = 1'b0;
    reg_wsel   = rs;
    reg_wdata  = operand;
    push       = 1'b0;

    case (state)
      S_IDLE: begin
        if (run) begin
          pc_d    = startaddr;
          sp_d    = '0;
          fault_d = 1'b0;
          led_d   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        c_raddr_d = pc;
        state_d   = S_WAIT;
      end
      S_WAIT: state_d = S_OPLOAD;
      S_OPLOAD: begin
        opcode_d = dread;
        pc_d     = pc_inc;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        c_raddr_d = pc;
        state_d   = S_FETCH;
        if (opcode[7]) begin
          state_d = S_WAIT2;
        end else if (opcode == OP_HLT) begin
          halted_d = 1'b1;
          state_d  = S_IDLE;
        end else if (opcode == OP_OUT) begin
          state_d = S_TXWAIT;
        end else if (opcode == OP_IN) begin
          state_d = S_RXWAIT;
        end else if (opcode == OP_CLF) begin
          flags_d = '0;
        end else if (opcode == OP_RTS) begin
          if (sp == '0) begin
            fault_d  = 1'b1;
            halted_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            sp_d = sp_dec;
            pc_d = stack[sp_dec];
          end
        end else if (op_match(opcode, MOV_MASK, MOV_BASE)) begin
          if (reg_ok(rd) && reg_ok(rs)) begin
            reg_we    = 1'b1;
            reg_wsel  = rd;
            reg_wdata = regs[rs];
          end
        end else if (op_match(opcode, ALU_MASK, ALU_BASE)) begin
          if (reg_ok(rs)) begin
            flags_d[FLAG_Z] = alu_zero;
            flags_d[FLAG_C] = alu_carry;
            if (opcode[5:3] != ALU_CMP) begin
              reg_we    = 1'b1;
              reg_wsel  = 2'd0;
              reg_wdata = alu_result;
            end
          end
        end
      end
      S_WAIT2: state_d = S_OPLOAD2;
      S_OPLOAD2: begin
        operand_d = dread;
        pc_d      = pc_inc;
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (op_match(opcode, REG_MASK, LDI_BASE)) begin
          reg_we = reg_ok(rs);
        end else if (op_match(opcode, REG_MASK, LD_BASE)) begin
          if (reg_ok(rs)) begin
            c_raddr_d = AW'(operand);
            state_d   = S_WAIT3;
          end
        end else if (op_match(opcode, REG_MASK, ST_BASE)) begin
          if (reg_ok(rs)) begin
            c_waddr_d  = AW'(operand);
            dwrite_d   = regs[rs];
            write_en_d = 1'b1;
          end
        end else if (op_match(opcode, JSR_MASK, JSR_BASE)) begin
          if (sp == SPW'(stack_depth)) begin
            fault_d  = 1'b1;
            halted_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            push = 1'b1;
            sp_d = SPW'(sp + 1'b1);
            pc_d = jsr_target;
          end
        end else if (br_taken) begin
          pc_d = br_target;
        end
      end
      S_WAIT3: state_d = S_MEMLOAD;
      S_MEMLOAD: begin
        reg_we    = reg_ok(rs);
        reg_wdata = dread;
        state_d   = S_FETCH;
      end
      S_TXWAIT: begin
        if (!is_transmitting) begin
          tx_byte_d  = regs[0];
          transmit_d = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_RXWAIT: begin
        if (received) begin
          reg_we    = 1'b1;
          reg_wsel  = 2'd0;
          reg_wdata = rx_byte;
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      pc       <= '0;
      opcode   <= '0;
      operand  <= '0;
      flags    <= '0;
      sp       <= '0;
      fault    <= 1'b0;
      c_raddr  <= '0;
      c_waddr  <= '0;
      dwrite   <= '0;
      tx_byte  <= '0;
      write_en <= 1'b0;
      transmit <= 1'b0;
      halted   <= 1'b0;
      led      <= 1'b0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      opcode   <= opcode_d;
      operand  <= operand_d;
      flags    <= flags_d;
      sp       <= sp_d;
      fault    <= fault_d;
      c_raddr  <= c_raddr_d;
      c_waddr  <= c_waddr_d;
      dwrite   <= dwrite_d;
      tx_byte  <= tx_byte_d;
      write_en <= write_en_d;
      transmit <= transmit_d;
      halted   <= halted_d;
      led      <= led_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[reg_wsel] <= reg_wdata;
    end
  end

  // Return addresses need no reset; sp alone defines which entries are live
  always_ff @(posedge clk) begin
    if (push) stack[sp] <= pc;
  end

endmodule

// File: tb/tb_cpu_gen2.sv
// Directed self-checking bench for cpu_gen2 with a 2-cycle block RAM and UART stubs.
module tb_cpu_gen2;
  import cpu_gen2_pkg::*;

  localparam int unsigned AW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run = 1'b0;
  logic [AW-1:0] startaddr = '0;
  logic [7:0]    dread;
  logic [AW-1:0] c_raddr, c_waddr;
  logic [7:0]    dwrite, tx_byte;
  logic          write_en, transmit, halted, fault, led;
  logic          is_transmitting = 1'b0;
  logic          received = 1'b0;
  logic [7:0]    rx_byte = 8'h00;

  logic [7:0]    mem [512];
  logic [7:0]    rd_q;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tx_cnt, halt_cnt, led_cnt, wr_cnt, led_cyc, halt_cyc;
  logic [7:0]    tx_log [16];
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  cpu_gen2 dut (
    .clk             (clk),
    .rst             (rst),
    .run             (run),
    .startaddr       (startaddr),
    .dread           (dread),
    .c_raddr         (c_raddr),
    .c_waddr         (c_waddr),
    .dwrite          (dwrite),
    .write_en        (write_en),
    .tx_byte         (tx_byte),
    .transmit        (transmit),
    .is_transmitting (is_transmitting),
    .received        (received),
    .rx_byte         (rx_byte),
    .halted          (halted),
    .fault           (fault),
    .led             (led)
  );

  always #5 clk = ~clk;

  // Registered address in the core plus one read register here = 2-cycle latency
  always @(posedge clk) begin
    rd_q <= mem[c_raddr];
    if (write_en) mem[c_waddr] = dwrite;
    cyc = cyc + 1;
  end
  assign dread = rd_q;

  always @(negedge clk) begin
    if (transmit) begin
      tx_log[tx_cnt % 16] = tx_byte;
      tx_cnt++;
    end
    if (halted) begin
      halt_cnt++;
      halt_cyc = cyc;
    end
    if (led) begin
      led_cnt++;
      led_cyc = cyc;
    end
    if (write_en) begin
      wr_cnt++;
      wr_addr = c_waddr;
      wr_data = dwrite;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic prog(input int base, input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++) mem[base + i] = bytes[8*(n-1-i) +: 8];
  endtask

  task automatic clear_counts();
    tx_cnt = 0; halt_cnt = 0; led_cnt = 0; wr_cnt = 0;
  endtask

  task automatic start(input logic [AW-1:0] a, input string tag);
    @(negedge clk);
    startaddr = a;
    run = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b0;
    check({tag, "_led"}, 64'(led), 64'd1);
  endtask

  task automatic wait_halt(input int budget, input string tag);
    int n = 0;
    int h0 = halt_cnt;
    while (halt_cnt == h0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_halted"}, 64'(halt_cnt - h0), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    clear_counts();
    #3;
    check("reset_outputs", {c_raddr, c_waddr, dwrite, write_en, tx_byte, transmit,
                            halted, fault, led}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_idle", 64'(dut.state), 64'(S_IDLE));

    // Latency: HLT alone, LDI+HLT, LD+HLT
    prog(9'h000, 64'h00, 1);
    start(9'h000, "lat1");
    wait_halt(50, "lat1");
    check("lat_1byte", 64'(halt_cyc - led_cyc), 64'd4);
    @(negedge clk); #1;
    check("halt_pulse_width", 64'(halted), 64'd0);
    prog(9'h008, 64'h80_07_00, 3);
    start(9'h008, "lat2");
    wait_halt(50, "lat2");
    check("lat_2byte", 64'(halt_cyc - led_cyc), 64'd11);
    prog(9'h00C, 64'h84_40_00, 3);
    start(9'h00C, "lat3");
    wait_halt(50, "lat3");
    check("lat_ld", 64'(halt_cyc - led_cyc), 64'd13);

    // LDI R1,5; LDI R0,3; ADD R1; OUT; HLT
    prog(9'h010, 64'h81_05_80_03_41_01_00, 7);
    clear_counts();
    start(9'h010, "t1");
    wait_halt(200, "t1");
    check("t1_tx_cnt", 64'(tx_cnt), 64'd1);
    check("t1_tx_byte", 64'(tx_log[0]), 64'h08);
    check("t1_flags_cz", 64'(dut.flags), 64'b00);
    check("t1_fault", 64'(fault), 64'd0);

    // LDI R0,FF; LDI R1,1; ADD R1; BRC +2; HLT; HLT; SBC R1; OUT; HLT
    prog(9'h020, 64'h80_FF_81_01_41_93_02_00, 8);
    prog(9'h028, 64'h00_59_01_00, 4);
    clear_counts();
    start(9'h020, "t2");
    wait_halt(200, "t2");
    check("t2_brc_taken_tx_cnt", 64'(tx_cnt), 64'd1);
    check("t2_sbc_result", 64'(tx_log[0]), 64'hFE);
    check("t2_flags_cz", 64'(dut.flags), 64'b10);

    // LDI R0,5A; ST R0,40; LD R2,40; MOV R0,R2; OUT; HLT
    mem[9'h040] = 8'hEE;
    prog(9'h030, 64'h80_5A_88_40_86_40_12_01, 8);
    prog(9'h038, 64'h00, 1);
    clear_counts();
    start(9'h030, "t3");
    wait_halt(200, "t3");
    check("t3_wr_cnt", 64'(wr_cnt), 64'd1);
    check("t3_waddr", 64'(wr_addr), 64'h040);
    check("t3_wdata", 64'(wr_data), 64'h5A);
    check("t3_r2", 64'(dut.regs[2]), 64'h5A);
    check("t3_echo", 64'(tx_log[0]), 64'h5A);

    // Four nested subroutines, each prints after returning from its callee
    prog(9'h100, 64'hA1_40_80_AA_01_00, 6);
    prog(9'h140, 64'hA1_50_80_11_01_04, 6);
    prog(9'h150, 64'hA1_60_80_22_01_04, 6);
    prog(9'h160, 64'hA1_70_80_33_01_04, 6);
    prog(9'h170, 64'h80_44_01_04, 4);
    clear_counts();
    start(9'h100, "t4");
    wait_halt(800, "t4");
    check("t4_tx_cnt", 64'(tx_cnt), 64'd5);
    check("t4_ret0", 64'(tx_log[0]), 64'h44);
    check("t4_ret1", 64'(tx_log[1]), 64'h33);
    check("t4_ret2", 64'(tx_log[2]), 64'h22);
    check("t4_ret3", 64'(tx_log[3]), 64'h11);
    check("t4_main", 64'(tx_log[4]), 64'hAA);
    check("t4_sp", 64'(dut.sp), 64'd0);
    check("t4_fault", 64'(fault), 64'd0);

    // Fifth nesting level overflows the stack
    prog(9'h170, 64'hA1_80, 2);
    clear_counts();
    start(9'h100, "t5");
    wait_halt(800, "t5");
    check("t5_overflow_fault", 64'(fault), 64'd1);
    check("t5_tx_cnt", 64'(tx_cnt), 64'd0);
    repeat (5) @(negedge clk);
    #1;
    check("t5_fault_sticky", 64'(fault), 64'd1);
    check("t5_idle", 64'(dut.state), 64'(S_IDLE));

    // RTS on an empty stack
    prog(9'h1A0, 64'h04, 1);
    clear_counts();
    start(9'h1A0, "t6");
    check("t6_fault_cleared", 64'(fault), 64'd0);
    wait_halt(50, "t6");
    check("t6_underflow_fault", 64'(fault), 64'd1);

    // Stray rx/busy while idle must be ignored; then IN and OUT both stall
    received = 1'b1;
    rx_byte  = 8'h77;
    repeat (3) @(negedge clk);
    received = 1'b0;
    is_transmitting = 1'b1;
    prog(9'h1C0, 64'h02_01_00, 3);
    clear_counts();
    start(9'h1C0, "t7");
    repeat (20) @(negedge clk);
    rx_byte  = 8'h3C;
    received = 1'b1;
    @(negedge clk);
    received = 1'b0;
    rx_byte  = 8'h55;
    repeat (10) @(negedge clk);
    #1;
    check("t7_stall_no_tx", 64'(tx_cnt), 64'd0);
    check("t7_stall_no_halt", 64'(halt_cnt), 64'd0);
    is_transmitting = 1'b0;
    wait_halt(100, "t7");
    check("t7_tx_cnt", 64'(tx_cnt), 64'd1);
    check("t7_tx_byte", 64'(tx_log[0]), 64'h3C);

    // Async reset while a load is in WAIT3
    prog(9'h1D0, 64'h80_99_88_41_85_40_00, 7);
    start(9'h1D0, "t8");
    begin
      int n = 0;
      while (dut.state !== S_WAIT3 && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    check("t8_reach_wait3", 64'(dut.state), 64'(S_WAIT3));
    check("t8_ld_raddr", 64'(c_raddr), 64'h040);
    clear_counts();
    #2;
    rst = 1'b0;
    #1;
    check("t8_async_outputs", {c_raddr, c_waddr, dwrite, write_en, tx_byte, transmit,
                               halted, fault, led}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("t8_stay_idle", 64'(dut.state), 64'(S_IDLE));
    check("t8_no_strobes", 64'(wr_cnt + tx_cnt + halt_cnt + led_cnt), 64'd0);
    check("t8_r1_not_loaded", 64'(dut.regs[1]), 64'd0);
    check("t8_raddr_idle", 64'(c_raddr), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
